// File: rtl/chi_slice_stage.sv
// ----------------------------------------------------------------------------
// chi_slice_stage
//
// Purpose:
//   Deserialises the bit-serial theta output stream into 25-bit slices and
//   applies the Keccak chi step row-wise to each slice. Each processed slice
//   is presented downstream over a valid/ready handshake. A pass covers
//   SLICES slices. Collecting and holding never overlap: while a slice waits
//   downstream, no new bits are accepted.
//
// Optional build macro:
//   IOTA_EN - adds the 64-bit round-constant port rc and folds the iota step
//             into lane (x=0,y=0), which is out_slice[24], using rc[z].
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (aborts any pass in progress)
//   start      one-cycle pulse; begins a pass (only honoured in IDLE)
//   in_valid   in_bit is valid
//   in_bit     serial theta bit; the first bit of a slice lands in the MSB
//   in_ready   block accepts in_bit this cycle
//   out_valid  out_slice holds a processed slice
//   out_ready  downstream accepts out_slice
//   out_slice  processed slice (bit 24-p holds row p/5, column p%5)
//   out_index  slice index z of out_slice
//   done       one-cycle pulse after the last slice is accepted downstream
//   rc         (IOTA_EN only) round constant, stable for the whole pass
// ----------------------------------------------------------------------------
module chi_slice_stage #(
  parameter int SLICES = 64,
  localparam int BITS = 25
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            in_valid,
  input  logic            in_bit,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out_slice,
  output logic [5:0]      out_index,
`ifdef IOTA_EN
  input  logic [63:0]     rc,
`endif
  output logic            done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [4:0] LAST_BIT   = 5'd24;
  localparam logic [5:0] LAST_SLICE = 6'(SLICES - 1);

  // Chi over one slice. Bit position 24-(5y+x) holds lane (x,y), so each row
  // is five adjacent bits with x=0 at the row's most significant end.
  function automatic logic [BITS-1:0] chi_slice(input logic [BITS-1:0] a);
    logic [BITS-1:0] b;
    b = {BITS{1'b0}};
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        b[24 - (5*y + x)] = a[24 - (5*y + x)] ^
                            (~a[24 - (5*y + (x + 1) % 5)] &
                              a[24 - (5*y + (x + 2) % 5)]);
      end
    end
    return b;
  endfunction

  state_t          state_r;
  logic [4:0]      bit_cnt_r;
  logic [5:0]      slice_cnt_r;
  // Only the first 24 bits need storage; the 25th is taken straight from
  // in_bit on the accepting cycle so the chi result can be registered then.
  logic [23:0]     shift_r;
  logic            in_ready_r;
  logic            out_valid_r;
  logic [BITS-1:0] out_slice_r;
  logic [5:0]      out_index_r;
  logic            done_r;
  logic [BITS-1:0] chi_s;
  logic            accept_s;

  assign accept_s  = in_valid & in_ready_r;
  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_slice = out_slice_r;
  assign out_index = out_index_r;
  assign done      = done_r;

  // Chi (and iota when enabled) of the slice completed by the current bit.
  always_comb begin
    chi_s = chi_slice({shift_r, in_bit});
`ifdef IOTA_EN
    chi_s[24] = chi_s[24] ^ rc[slice_cnt_r];
`endif
  end

  // Control FSM with registered handshake outputs and the slice datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      bit_cnt_r   <= 5'd0;
      slice_cnt_r <= 6'd0;
      shift_r     <= 24'd0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_slice_r <= {BITS{1'b0}};
      out_index_r <= 6'd0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r     <= COLLECT;
            bit_cnt_r   <= 5'd0;
            slice_cnt_r <= 6'd0;
            in_ready_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end

        COLLECT: begin
          if (accept_s) begin
            shift_r <= {shift_r[22:0], in_bit};
            if (bit_cnt_r == LAST_BIT) begin
              out_slice_r <= chi_s;
              out_index_r <= slice_cnt_r;
              bit_cnt_r   <= 5'd0;
              in_ready_r  <= 1'b0;
              out_valid_r <= 1'b1;
              state_r     <= HOLD;
            end else begin
              bit_cnt_r <= bit_cnt_r + 5'd1;
            end
          end else begin
            state_r <= COLLECT;
          end
        end

        HOLD: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            if (slice_cnt_r == LAST_SLICE) begin
              done_r  <= 1'b1;
              state_r <= DONE;
            end else begin
              slice_cnt_r <= slice_cnt_r + 6'd1;
              in_ready_r  <= 1'b1;
              state_r     <= COLLECT;
            end
          end else begin
            state_r <= HOLD;
          end
        end

        DONE: begin
          done_r      <= 1'b0;
          slice_cnt_r <= 6'd0;
          state_r     <= IDLE;
        end

        default: begin
          state_r     <= IDLE;
          bit_cnt_r   <= 5'd0;
          slice_cnt_r <= 6'd0;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          done_r      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/chi_slice_stage.md
Name: chi_slice_stage

Overview:
Downstream neighbour of the column-parity (theta) stage.
- Consumes the serial theta output stream: one bit per cycle, 25 bits per slice, 64 slices per state.
- Deserialises each slice into a 25-bit register and applies the chi nonlinear step row-wise.
- Presents each finished slice to the next stage over a valid/ready handshake.

Parameters:
SLICES, 64, number of slices (depths) per state; slice counter wraps after SLICES-1
BITS, 25, bits per slice (5 rows x 5 columns); fixed, not to be overridden

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse; begins a 64-slice pass (ignored unless IDLE)
in_valid  input  1  in_bit valid from theta stage
in_bit  input  1  serial theta output bit
in_ready  output  1  block accepts in_bit this cycle
out_valid  output  1  out_slice holds a chi-processed slice
out_ready  input  1  downstream accepts out_slice
out_slice  output  25  processed slice, MSB = first received bit
out_index  output  6  slice index z of out_slice (0..63)
done  output  1  one-cycle pulse after slice 63 is accepted downstream

Behaviour:
- Reset (rst=1 at clock edge): state=IDLE, in_ready=0, out_valid=0, out_slice=0, out_index=0, done=0, bit counter=0, slice counter=0. Reset mid-pass aborts the pass; no partial output.
- Bit mapping: the p-th accepted bit of a slice (p=0..24) goes to slice[24-p]; x=p mod 5, y=p/5.
- Chi, per row y: b[x] = a[x] ^ (~a[(x+1) mod 5] & a[(x+2) mod 5]).
- FSM:
  - IDLE: in_ready=0. start -> COLLECT, counters cleared.
  - COLLECT: in_ready=1. Each in_valid&in_ready cycle shifts in one bit and increments the bit counter (0..24). On the 25th accept (bit counter=24):
    - chi of the completed slice is registered into out_slice;
    - out_index is set to the slice counter;
    - bit counter resets to 0;
    - -> HOLD.
  - HOLD: out_valid=1, in_ready=0. out_slice and out_index are stable until the handshake.
    - On out_valid&out_ready with slice counter < 63: increment slice counter, -> COLLECT.
    - On the handshake with slice counter = 63: -> DONE.
  - DONE: done=1 for exactly one cycle, slice counter wraps to 0, -> IDLE.
- Latency: out_valid rises the cycle after the 25th bit is accepted. in_ready returns the cycle after the handshake. No overlap of collect and hold.
- in_valid=0 in COLLECT: hold state and counters, no shift.
- start while not IDLE: ignored.
- in_valid while in_ready=0: bit is not consumed; upstream must hold it.
- out_ready while out_valid=0: no effect.

Optional Feature:
IOTA_EN
- Defined:
  - adds input port rc (64 bits, the round constant, held stable for the pass);
  - for slice z, out_slice[24] (lane x=0,y=0) = chi result ^ rc[z];
  - merges the iota step into this stage.
- Undefined: no rc port; pure chi.

Test Plan:
- Reset mid-COLLECT after 10 bits, then start and 25 zero bits -> out_valid=1 one cycle after 25th bit, out_slice=25'h0000000, out_index=0.
- Slice with only p=1 set (bit stream 0,1,0...0) -> out_slice=25'h0900000 (rows: x=1 and x=4 set in row 0).
- All-ones slice -> out_slice=25'h1FFFFFF; all-zeros -> 25'h0000000.
- Full pass of 64 slices with out_ready tied 1 -> out_index 0..63 in order, done pulses once, one cycle after the slice-63 handshake, then IDLE.
- Backpressure: hold out_ready=0 for 7 cycles in HOLD -> out_slice and out_index stable, in_ready=0. Pulse start during HOLD -> no effect. Random in_valid gaps in COLLECT -> results unchanged versus gap-free run.
- With IOTA_EN, rc=64'h0000000000000001:
  - slice 0 all-zero -> out_slice=25'h1000000;
  - slice 1 all-zero -> 25'h0000000.
